conv_scheduler: RTL and testbench
=================================

Name: conv_scheduler

Overview:
- Sequences the convolution datapath over a full output feature map (OFM).
- For each output pixel it:
  - loads one KxK input window from IFMap memory;
  - runs the MAC once per filter against that shared window;
  - writes each filter result to the OFM.
- Sits between the top-level start/ready handshake and the window buffer, MAC unit and OFM write port, replacing ad-hoc counter control.

Parameters:
- N, 4: number of filters sharing the MAC; results per output pixel.
- IFM_W, 16: IFMap width and height (square map), in pixels.
- K, 3: kernel width and height; stride is fixed at 1, no padding.
- MEM_AW, 10: IFMap memory address width.
- OFM_AW, 8: OFM address width; must satisfy (IFM_W-K+1)^2 <= 2^OFM_AW.
- Derived: OFM_W = IFM_W-K+1; P = OFM_W^2; FW = max(1, clog2(N)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a full OFM pass; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- ready  out  1  one-cycle pulse when the pass completes.
- busy  out  1  high whenever state != IDLE.
- win_ld  out  1  one-cycle strobe: load the window at win_base.
- win_base  out  MEM_AW  IFMap address of the window's top-left pixel, oy*IFM_W+ox.
- win_done  in  1  window buffer filled; honoured only in WAIT_WIN.
- mac_start  out  1  one-cycle strobe: start the MAC with filter filt_sel.
- filt_sel  out  FW  current filter index.
- mac_done  in  1  MAC result valid; honoured only in WAIT_MAC.
- ofm_we  out  1  one-cycle OFM write enable.
- ofm_addr  out  OFM_AW  oy*OFM_W+ox.

Behaviour:
- Reset, asynchronous, active-low:
  - state goes to IDLE; ox, oy, f are cleared to 0;
  - every output is 0, including win_base, filt_sel and ofm_addr.
- Moore FSM; each strobe output is high for exactly the one cycle its state is occupied.
- States and transitions:
  - IDLE: start=1 -> LOAD; ox, oy, f cleared.
  - LOAD: win_ld=1 -> WAIT_WIN.
  - WAIT_WIN: win_done=1 -> MAC; otherwise stay.
  - MAC: mac_start=1 -> WAIT_MAC.
  - WAIT_MAC: mac_done=1 -> WRITE; otherwise stay.
  - WRITE: ofm_we=1.
    - If f < N-1: f increments and the FSM goes to MAC; the window is not reloaded.
    - Otherwise: f cleared, FSM goes to NEXT.
  - NEXT: no strobes.
    - If ox = OFM_W-1 and oy = OFM_W-1: go to DONE.
    - Else if ox = OFM_W-1: ox cleared, oy increments, go to LOAD.
    - Else: ox increments, go to LOAD.
  - DONE: ready=1 -> IDLE.
- win_base, ofm_addr and filt_sel are combinational from the registered ox, oy and f.
  - They are stable throughout each strobe and its wait state.
  - Arithmetic is unsigned and wide enough that no intermediate wraps.
- Handshakes:
  - A done input high in the same cycle as its strobe is ignored: the wait state is entered on the following edge.
  - A done input held high is consumed once per wait-state visit.
  - Done inputs arriving in any other state are ignored.
- start high while busy is ignored; no queueing.
- abort=1 in any non-IDLE state:
  - next state is IDLE, counters cleared, no ready pulse;
  - abort has priority over every other transition.
- abort in IDLE is ignored.
- If abort and start are both high in IDLE, start wins and the FSM goes to LOAD.
- Throughput with done inputs returning the cycle after each strobe:
  - per pixel: LOAD, WAIT_WIN, N x (MAC, WAIT_MAC, WRITE), NEXT = 3+3N cycles;
  - full pass: P*(3+3N)+1 cycles from the start-sampling edge to the ready pulse, DONE included.
- Total OFM writes per pass: exactly P*N.
- Writes are ordered by pixel (raster order, ox fastest), then by filter 0..N-1.

Test Plan:
- Small config IFM_W=4, K=3, N=2 (OFM_W=2, P=4); instant done responders; single start.
  - win_base sequence: 0, 1, 4, 5.
  - 8 ofm_we pulses with (ofm_addr, filt_sel) = (0,0) (0,1) (1,0) (1,1) (2,0) (2,1) (3,0) (3,1).
  - ready asserted 37 cycles after start is sampled.
- Delayed handshake: win_done 5 cycles late and mac_done 3 cycles late.
  - FSM holds in the wait states; win_base, filt_sel and ofm_addr stay stable; no extra strobes.
  - A mac_done pulse coincident with mac_start is ignored.
- Spurious inputs: mac_done held high while in IDLE/LOAD, start pulsed mid-pass.
  - No state change, no second pass, write count stays 8.
- abort asserted while in WAIT_MAC at pixel 2.
  - Next cycle: busy=0, all strobes 0, no ready.
  - A new start restarts the pass from win_base=0.
- rst driven low asynchronously mid-WRITE, between clock edges.
  - Outputs go to 0 immediately.
  - After rst is released, a start runs a clean full pass.
- Default parameters (IFM_W=16, K=3, N=4).
  - Last write has ofm_addr=195, filt_sel=3; last win_base = 13*16+13 = 221.
  - 784 writes; ready after 196*15+1 = 2941 cycles.

Source files
------------

// File: rtl/conv_scheduler.sv
// Control FSM for the convolution datapath: walks every output pixel in raster
// order, loads its KxK window once, then runs and writes the MAC for N filters.
module conv_scheduler #(
  parameter int N      = 4,
  parameter int IFM_W  = 16,
  parameter int K      = 3,
  parameter int MEM_AW = 10,
  parameter int OFM_AW = 8,
  localparam int OFM_W = IFM_W - K + 1,
  localparam int FW    = (N > 1) ? $clog2(N) : 1,
  localparam int CW    = (OFM_W > 1) ? $clog2(OFM_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              win_ld,
  output logic [MEM_AW-1:0] win_base,
  input  logic              win_done,
  output logic              mac_start,
  output logic [FW-1:0]     filt_sel,
  input  logic              mac_done,
  output logic              ofm_we,
  output logic [OFM_AW-1:0] ofm_addr
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_WIN, MAC, WAIT_MAC, WRITE, NEXT, DONE
  } stateT;

  localparam logic [CW-1:0] LAST_POS  = CW'(OFM_W - 1);
  localparam logic [FW-1:0] LAST_FILT = FW'(N - 1);

  stateT         state, nextState;
  logic [CW-1:0] ox, oy, oxNext, oyNext;
  logic [FW-1:0] f, fNext;

  always_comb begin
    nextState = state;
    oxNext    = ox;
    oyNext    = oy;
    fNext     = f;
    case (state)
      IDLE: if (start) begin
        nextState = LOAD;
        oxNext    = '0;
        oyNext    = '0;
        fNext     = '0;
      end
      LOAD:     nextState = WAIT_WIN;
      WAIT_WIN: if (win_done) nextState = MAC;
      MAC:      nextState = WAIT_MAC;
      WAIT_MAC: if (mac_done) nextState = WRITE;
      WRITE: begin
        // The window stays resident while the remaining filters reuse it.
        if (f == LAST_FILT) begin
          fNext     = '0;
          nextState = NEXT;
        end else begin
          fNext     = f + 1'b1;
          nextState = MAC;
        end
      end
      NEXT: begin
        if (ox == LAST_POS) begin
          if (oy == LAST_POS) begin
            nextState = DONE;
          end else begin
            oxNext    = '0;
            oyNext    = oy + 1'b1;
            nextState = LOAD;
          end
        end else begin
          oxNext    = ox + 1'b1;
          nextState = LOAD;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort && state != IDLE) begin
      nextState = IDLE;
      oxNext    = '0;
      oyNext    = '0;
      fNext     = '0;
    end
  end

  // Strobes are registered from the next state so each one exactly tracks
  // occupancy of its state with no decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ox        <= '0;
      oy        <= '0;
      f         <= '0;
      busy      <= 1'b0;
      win_ld    <= 1'b0;
      mac_start <= 1'b0;
      ofm_we    <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= nextState;
      ox        <= oxNext;
      oy        <= oyNext;
      f         <= fNext;
      busy      <= (nextState != IDLE);
      win_ld    <= (nextState == LOAD);
      mac_start <= (nextState == MAC);
      ofm_we    <= (nextState == WRITE);
      ready     <= (nextState == DONE);
    end
  end

  assign win_base = MEM_AW'(oy) * MEM_AW'(IFM_W) + MEM_AW'(ox);
  assign ofm_addr = OFM_AW'(oy) * OFM_AW'(OFM_W) + OFM_AW'(ox);
  assign filt_sel = f;

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: a small (4x4, K=3, N=2) instance for the
// handshake/abort/reset scenarios and a default-sized instance for a full pass.
module tb_conv_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, sel;
  logic macForce, macEarly, winPulse, macPulse;
  int   winLat, macLat, winCnt, macCnt;
  int   curN, curOW, curIW;
  int   checks, errors;
  int   cyc, readyCyc, readyCnt, winLds, macStarts, writes;
  int   lastBase, lastAddr, lastFilt;

  logic startS, abortS, winDoneS, macDoneS, startD, abortD, winDoneD, macDoneD;
  assign startS   = start && !sel;
  assign abortS   = abort && !sel;
  assign winDoneS = winPulse && !sel;
  assign macDoneS = (macForce || macPulse) && !sel;
  assign startD   = start && sel;
  assign abortD   = abort && sel;
  assign winDoneD = winPulse && sel;
  assign macDoneD = (macForce || macPulse) && sel;

  logic       readyS, busyS, winLdS, macStartS, ofmWeS;
  logic [9:0] winBaseS;
  logic [0:0] filtSelS;
  logic [7:0] ofmAddrS;
  logic       readyD, busyD, winLdD, macStartD, ofmWeD;
  logic [9:0] winBaseD;
  logic [1:0] filtSelD;
  logic [7:0] ofmAddrD;

  conv_scheduler #(.N(2), .IFM_W(4), .K(3), .MEM_AW(10), .OFM_AW(8)) dutS (
    .clk(clk), .rst(rst), .start(startS), .abort(abortS), .ready(readyS),
    .busy(busyS), .win_ld(winLdS), .win_base(winBaseS), .win_done(winDoneS),
    .mac_start(macStartS), .filt_sel(filtSelS), .mac_done(macDoneS),
    .ofm_we(ofmWeS), .ofm_addr(ofmAddrS)
  );

  conv_scheduler dutD (
    .clk(clk), .rst(rst), .start(startD), .abort(abortD), .ready(readyD),
    .busy(busyD), .win_ld(winLdD), .win_base(winBaseD), .win_done(winDoneD),
    .mac_start(macStartD), .filt_sel(filtSelD), .mac_done(macDoneD),
    .ofm_we(ofmWeD), .ofm_addr(ofmAddrD)
  );

  logic        readyM, busyM, winLdM, macStartM, ofmWeM;
  logic [31:0] winBaseM, filtSelM, ofmAddrM;
  assign readyM    = sel ? readyD : readyS;
  assign busyM     = sel ? busyD : busyS;
  assign winLdM    = sel ? winLdD : winLdS;
  assign macStartM = sel ? macStartD : macStartS;
  assign ofmWeM    = sel ? ofmWeD : ofmWeS;
  assign winBaseM  = sel ? 32'(winBaseD) : 32'(winBaseS);
  assign filtSelM  = sel ? 32'(filtSelD) : 32'(filtSelS);
  assign ofmAddrM  = sel ? 32'(ofmAddrD) : 32'(ofmAddrS);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, score strobes, then drive
  // the done responders for the following cycle.
  task automatic tick();
    int p;
    @(posedge clk);
    #1;
    cyc++;
    if (busyM && !winLdM && winLds > 0) check("base_stable", winBaseM, lastBase);
    if (winLdM) begin
      p = winLds;
      check("win_base", winBaseM, (p / curOW) * curIW + p % curOW);
      lastBase = winBaseM;
      winLds++;
    end
    if (macStartM) begin
      check("mac_filt", filtSelM, macStarts % curN);
      macStarts++;
    end
    if (ofmWeM) begin
      check("wr_addr", ofmAddrM, writes / curN);
      check("wr_filt", filtSelM, writes % curN);
      lastAddr = ofmAddrM;
      lastFilt = filtSelM;
      writes++;
    end
    if (readyM) begin
      readyCyc = cyc;
      readyCnt++;
    end
    if (winLdM) begin
      winCnt = winLat; winPulse = 1'b0;
    end else if (winCnt > 0) begin
      winCnt--; winPulse = (winCnt == 0);
    end else winPulse = 1'b0;
    if (macStartM) begin
      macCnt = macLat; macPulse = macEarly;
    end else if (macCnt > 0) begin
      macCnt--; macPulse = (macCnt == 0);
    end else macPulse = 1'b0;
  endtask

  task automatic clearStats();
    cyc = 0; readyCyc = -1; readyCnt = 0; winLds = 0; macStarts = 0; writes = 0;
    winCnt = 0; macCnt = 0; winPulse = 1'b0; macPulse = 1'b0;
  endtask

  task automatic finishPass(input int budget, input int midStart, input bit spur);
    while (readyCnt == 0 && cyc < budget) begin
      if (spur && cyc == 2) macForce = 1'b0;
      start = (cyc == midStart);
      tick();
    end
    start = 1'b0;
    if (readyCnt == 0) check("ready_timeout", 0, 1);
  endtask

  task automatic runPass(input int budget, input int midStart, input bit spur);
    clearStats();
    if (spur) begin
      macForce = 1'b1;
      repeat (3) begin
        tick();
        check("idle_spur_busy", busyM, 0);
      end
      clearStats();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    finishPass(budget, midStart, spur);
  endtask

  task automatic idleTicks(input int n);
    repeat (n) begin
      tick();
      check("post_idle_busy", busyM, 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
    macForce = 1'b0; macEarly = 1'b0; winLat = 1; macLat = 1;
    curN = 2; curOW = 2; curIW = 4; lastBase = 0; lastAddr = 0; lastFilt = 0;
    clearStats();

    #3;
    check("rst_busy_s", busyS, 0);
    check("rst_strobes_s", {readyS, winLdS, macStartS, ofmWeS}, 0);
    check("rst_addrs_s", {winBaseS, filtSelS, ofmAddrS}, 0);
    check("rst_busy_d", busyD, 0);
    check("rst_strobes_d", {readyD, winLdD, macStartD, ofmWeD}, 0);
    check("rst_addrs_d", {winBaseD, filtSelD, ofmAddrD}, 0);
    #14 rst = 1'b1;
    abort = 1'b1;
    tick();
    check("abort_idle_busy", busyM, 0);
    abort = 1'b0;

    // Back-to-back responders: 4 pixels * 9 + DONE.
    runPass(200, 0, 0);
    check("p1_ready_cyc", readyCyc, 37);
    check("p1_writes", writes, 8);
    check("p1_loads", winLds, 4);
    check("p1_macs", macStarts, 8);
    idleTicks(3);
    check("p1_ready_once", readyCnt, 1);

    // Late handshakes: 6 wait cycles per window, 4 per MAC, early mac_done ignored.
    winLat = 6; macLat = 4; macEarly = 1'b1;
    runPass(400, 0, 0);
    check("p2_ready_cyc", readyCyc, 4 * (1 + 6 + 2 * 6 + 1) + 1);
    check("p2_writes", writes, 8);
    check("p2_loads", winLds, 4);
    check("p2_macs", macStarts, 8);
    winLat = 1; macLat = 1; macEarly = 1'b0;
    idleTicks(2);

    // mac_done held through IDLE/LOAD plus a start pulse mid-pass.
    runPass(200, 15, 1);
    check("p3_ready_cyc", readyCyc, 37);
    check("p3_writes", writes, 8);
    idleTicks(5);
    check("p3_writes_after", writes, 8);
    check("p3_ready_once", readyCnt, 1);

    // Abort while waiting on the first MAC of pixel 2.
    clearStats();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (macStarts < 2 * curN + 1 && cyc < 100) begin
      if (winLds == 3) macLat = 30;
      tick();
    end
    check("ab_reached", macStarts, 2 * curN + 1);
    tick();
    check("ab_wait_base", winBaseM, 4);
    check("ab_wait_addr", ofmAddrM, 2);
    check("ab_wait_filt", filtSelM, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busyM, 0);
    check("ab_strobes", {readyM, winLdM, macStartM, ofmWeM}, 0);
    check("ab_cleared", {winBaseM[15:0], ofmAddrM[7:0], filtSelM[7:0]}, 0);
    check("ab_writes", writes, 4);
    macLat = 1;
    idleTicks(2);
    check("ab_no_ready", readyCnt, 0);
    // start together with abort in IDLE: start wins.
    clearStats();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("ab_start_wins", winLdM, 1);
    finishPass(200, 0, 0);
    check("ab_restart_ready", readyCyc, 37);
    check("ab_restart_writes", writes, 8);
    idleTicks(2);

    // Asynchronous reset between edges during the third write.
    clearStats();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (writes < 3 && cyc < 100) tick();
    check("rs_in_write", {ofmWeM, ofmAddrM[7:0]}, {1'b1, 8'd1});
    #2 rst = 1'b0;
    #1;
    check("rs_busy", busyS, 0);
    check("rs_strobes", {readyS, winLdS, macStartS, ofmWeS}, 0);
    check("rs_addrs", {winBaseS, filtSelS, ofmAddrS}, 0);
    #3 rst = 1'b1;
    clearStats();
    idleTicks(2);
    runPass(200, 0, 0);
    check("rs_ready_cyc", readyCyc, 37);
    check("rs_writes", writes, 8);
    idleTicks(2);

    // Default-sized instance, full pass.
    sel = 1'b1; curN = 4; curOW = 14; curIW = 16;
    idleTicks(1);
    runPass(3200, 0, 0);
    check("def_ready_cyc", readyCyc, 196 * 15 + 1);
    check("def_writes", writes, 784);
    check("def_loads", winLds, 196);
    check("def_last_base", lastBase, 221);
    check("def_last_addr", lastAddr, 195);
    check("def_last_filt", lastFilt, 3);
    idleTicks(2);
    check("def_ready_once", readyCnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
